// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter-side bundle of the UART transmit arbiter.
// The arbiter takes the slave modport; the producers/transmitter side takes the master modport.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   ack;
   logic                 tx_busy;
   logic [7:0]           tx_data;
   logic                 tx_data_ready;
   logic [IDW-1:0]       grant_id;
   logic                 active;

   modport master (
      output req, req_data, tx_busy,
      input  ack, tx_data, tx_data_ready, grant_id, active
   );

   modport slave (
      input  req, req_data, tx_busy,
      output ack, tx_data, tx_data_ready, grant_id, active
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Define UART_ARB_TAG_EN to prefix every granted byte with an ASCII tag byte ("0" + grant_id).
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int BUSY_TIMEOUT = 8,
   parameter int IDW          = $clog2(NUM_REQ)
) (
   input logic             clk_25mhz,
   input logic             resetn,
   uart_tx_arbiter_if.slave bus
);
   localparam int                CNT_W    = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
   localparam logic [IDW-1:0]    LAST_RST = IDW'(NUM_REQ - 1);

   typedef enum logic [2:0] {
      IDLE,
      STROBE,
      WAIT_BUSY,
      WAIT_DONE
`ifdef UART_ARB_TAG_EN
      ,
      TAG_STROBE,
      TAG_WAIT_BUSY,
      TAG_WAIT_DONE
`endif
   } state_t;

   state_t             state, state_nxt;
   logic [IDW-1:0]     last, last_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [NUM_REQ-1:0] ack_nxt;
   logic [7:0]         tx_data_nxt;
   logic               rdy_nxt;
   logic [IDW-1:0]     grant_nxt;
   logic               active_nxt;
   logic               frame_end;
   logic [IDW-1:0]     pick_idx;
   logic               pick_vld;
   logic [7:0]         pick_byte;
`ifdef UART_ARB_TAG_EN
   logic [7:0]         payload, payload_nxt;
   logic               tag_end;
`endif

   // Round-robin search from last+1; scanning backwards lets the nearest candidate win.
   always_comb begin : rr_search
      int idx;
      idx       = 0;
      pick_vld  = 1'b0;
      pick_idx  = '0;
      pick_byte = 8'h00;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = int'(last) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (bus.req[IDW'(idx)]) begin
            pick_vld = 1'b1;
            pick_idx = IDW'(idx);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == IDW'(i)) pick_byte = bus.req_data[8*i +: 8];
      end
   end

   always_comb begin
      state_nxt   = state;
      last_nxt    = last;
      cnt_nxt     = cnt;
      ack_nxt     = '0;
      tx_data_nxt = bus.tx_data;
      rdy_nxt     = 1'b0;
      grant_nxt   = bus.grant_id;
      active_nxt  = bus.active;
      frame_end   = 1'b0;
`ifdef UART_ARB_TAG_EN
      payload_nxt = payload;
      tag_end     = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (pick_vld && !bus.tx_busy) begin
               ack_nxt[pick_idx] = 1'b1;
               grant_nxt         = pick_idx;
               last_nxt          = pick_idx;
               active_nxt        = 1'b1;
`ifdef UART_ARB_TAG_EN
               tx_data_nxt = 8'h30 + 8'(pick_idx);
               payload_nxt = pick_byte;
               state_nxt   = TAG_STROBE;
`else
               tx_data_nxt = pick_byte;
               state_nxt   = STROBE;
`endif
            end
         end
         STROBE: begin
            rdy_nxt   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = WAIT_BUSY;
         end
         // A transmitter that never raises busy is treated as having finished the frame.
         WAIT_BUSY: begin
            if (bus.tx_busy)          state_nxt = WAIT_DONE;
            else if (cnt == CNT_LAST) frame_end = 1'b1;
            else                      cnt_nxt   = cnt + CNT_W'(1);
         end
         WAIT_DONE: begin
            if (!bus.tx_busy) frame_end = 1'b1;
         end
`ifdef UART_ARB_TAG_EN
         TAG_STROBE: begin
            rdy_nxt   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = TAG_WAIT_BUSY;
         end
         TAG_WAIT_BUSY: begin
            if (bus.tx_busy)          state_nxt = TAG_WAIT_DONE;
            else if (cnt == CNT_LAST) tag_end   = 1'b1;
            else                      cnt_nxt   = cnt + CNT_W'(1);
         end
         TAG_WAIT_DONE: begin
            if (!bus.tx_busy) tag_end = 1'b1;
         end
`endif
         default: state_nxt = IDLE;
      endcase

      if (frame_end) begin
         active_nxt = 1'b0;
         state_nxt  = IDLE;
      end
`ifdef UART_ARB_TAG_EN
      // Tag byte done: present the held payload and run a second strobe sequence.
      if (tag_end) begin
         tx_data_nxt = payload;
         state_nxt   = STROBE;
      end
`endif
   end

   always_ff @(posedge clk_25mhz) begin
      if (!resetn) begin
         state             <= IDLE;
         last              <= LAST_RST;
         cnt               <= '0;
         bus.ack           <= '0;
         bus.tx_data       <= 8'h00;
         bus.tx_data_ready <= 1'b0;
         bus.grant_id      <= '0;
         bus.active        <= 1'b0;
      end else begin
         state             <= state_nxt;
         last              <= last_nxt;
         cnt               <= cnt_nxt;
         bus.ack           <= ack_nxt;
         bus.tx_data       <= tx_data_nxt;
         bus.tx_data_ready <= rdy_nxt;
         bus.grant_id      <= grant_nxt;
         bus.active        <= active_nxt;
      end
   end

`ifdef UART_ARB_TAG_EN
   always_ff @(posedge clk_25mhz) begin
      payload <= payload_nxt;
   end
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: random producers and a transmitter busy model,
// with a round-robin reference model predicting every ack and every transmitter strobe.
module tb_uart_tx_arbiter;
   localparam int NUM_REQ      = 4;
   localparam int BUSY_TIMEOUT = 8;
   localparam int IDW          = 2;

   logic clk_25mhz = 1'b0;
   logic resetn    = 1'b0;
   always #20 clk_25mhz = ~clk_25mhz;

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus ();

   uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT), .IDW(IDW)) dut (
      .clk_25mhz (clk_25mhz),
      .resetn    (resetn),
      .bus       (bus)
   );

   typedef struct {
      logic [7:0] val;
      int         cyc;
   } exp_t;

   exp_t               exp_q[$];
   logic [7:0]         strobe_log[$];
   logic [7:0]         dat[NUM_REQ];
   logic [NUM_REQ-1:0] req_v       = '0;
   logic [NUM_REQ-1:0] inject      = '0;
   logic [NUM_REQ-1:0] first_ack   = '0;
   int                 n_tests     = 0;
   int                 n_fail      = 0;
   int                 cyc         = 0;
   int                 req_mode    = 2;   // 0: no new requests, 1: random, 2: all continuous
   int                 busy_len    = 3;   // 0: transmitter never raises busy
   bit                 rand_busy   = 1'b0;
   bit                 chk_spacing = 1'b0;
   bit                 want_first  = 1'b0;
   int                 model_last  = NUM_REQ - 1;
   int                 strobe_cnt  = 0;
   int                 last_strobe = -1000;
   int                 busy_cnt    = 0;
   int                 fall_cyc    = -1;

   always @(posedge clk_25mhz) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
      int idx;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (last + k) % NUM_REQ;
         if (r[idx[IDW-1:0]]) return idx;
      end
      return -1;
   endfunction

   // Monitor, transmitter model and producers share one process so req snapshots stay ordered.
   initial begin
      int                 id;
      int                 len;
      logic [NUM_REQ-1:0] e;
      exp_t               x;
      for (int i = 0; i < NUM_REQ; i++) dat[i] = 8'h10 + 8'(i);
      bus.tx_busy  = 1'b0;
      bus.req      = '0;
      bus.req_data = '0;
      forever begin
         @(negedge clk_25mhz);
         if (!resetn) begin
            exp_q.delete();
            model_last  = NUM_REQ - 1;
            busy_cnt    = 0;
            bus.tx_busy = 1'b0;
            fall_cyc    = -1;
         end else begin
            if (bus.ack != '0) begin
               id = rr_pick(req_v, model_last);
               chk("ack_has_request", 32'(id >= 0), 1);
               if (id >= 0) begin
                  e = NUM_REQ'(1) << id;
                  chk("ack_onehot", 32'(bus.ack), 32'(e));
                  chk("grant_id", 32'(bus.grant_id), id);
                  chk("active_at_capture", 32'(bus.active), 1);
`ifdef UART_ARB_TAG_EN
                  chk("capture_tag", 32'(bus.tx_data), 32'h30 + id);
                  x.val = 8'h30 + 8'(id); x.cyc = cyc + 1; exp_q.push_back(x);
                  x.val = dat[id];        x.cyc = -1;      exp_q.push_back(x);
`else
                  chk("capture_data", 32'(bus.tx_data), 32'(dat[id]));
                  x.val = dat[id]; x.cyc = cyc + 1; exp_q.push_back(x);
`endif
                  model_last = id;
                  if (want_first) begin
                     first_ack  = bus.ack;
                     want_first = 1'b0;
                  end
                  if (chk_spacing) chk("timeout_spacing", cyc - last_strobe, BUSY_TIMEOUT + 1);
               end
            end
            if (bus.tx_data_ready) begin
               strobe_cnt++;
               strobe_log.push_back(bus.tx_data);
               chk("strobe_expected", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  x = exp_q.pop_front();
                  chk("strobe_data", 32'(bus.tx_data), 32'(x.val));
                  if (x.cyc >= 0) chk("strobe_latency", cyc, x.cyc);
               end
               chk("active_at_strobe", 32'(bus.active), 1);
               last_strobe = cyc;
            end
`ifndef UART_ARB_TAG_EN
            if (chk_spacing && cyc == last_strobe + BUSY_TIMEOUT) chk("timeout_idle", 32'(bus.active), 0);
            if (fall_cyc >= 0 && cyc == fall_cyc + 1) begin
               chk("active_after_busy", 32'(bus.active), 0);
               fall_cyc = -1;
            end
`endif
            if (busy_cnt > 0) begin
               busy_cnt--;
               if (busy_cnt == 0) begin
                  bus.tx_busy = 1'b0;
                  fall_cyc    = cyc;
               end
            end
            if (bus.tx_data_ready) begin
               len = rand_busy ? int'($urandom_range(0, 6)) : busy_len;
               if (len > 0) begin
                  bus.tx_busy = 1'b1;
                  busy_cnt    = len;
               end
            end
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_v[i]) begin
               if (resetn && bus.ack[i] && req_mode != 2) req_v[i] = 1'b0;
               else if (req_mode == 1 && !bus.ack[i] && $urandom_range(0, 31) == 0) req_v[i] = 1'b0;
            end else if (inject[i] || req_mode == 2) begin
               req_v[i] = 1'b1;
            end else if (req_mode == 1 && $urandom_range(0, 3) == 0) begin
               dat[i]   = 8'($urandom);
               req_v[i] = 1'b1;
            end
         end
         bus.req = req_v;
         for (int i = 0; i < NUM_REQ; i++) bus.req_data[8*i +: 8] = dat[i];
      end
   end

   task automatic wait_strobes(input int n, input int budget);
      int target;
      int t;
      target = strobe_cnt + n;
      t      = 0;
      while (strobe_cnt < target && t < budget) begin
         @(negedge clk_25mhz);
         t++;
      end
      chk("strobe_wait", 32'(strobe_cnt >= target), 1);
   endtask

   task automatic wait_idle(input int budget);
      int t;
      t = 0;
      while (!(req_v == '0 && !bus.active && !bus.tx_busy) && t < budget) begin
         @(negedge clk_25mhz);
         t++;
      end
      chk("idle_reached", 32'(req_v == '0 && !bus.active), 1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ack"},      32'(bus.ack), 0);
      chk({tag, "_tx_data"},  32'(bus.tx_data), 0);
      chk({tag, "_ready"},    32'(bus.tx_data_ready), 0);
      chk({tag, "_grant_id"}, 32'(bus.grant_id), 0);
      chk({tag, "_active"},   32'(bus.active), 0);
   endtask

   initial begin
      logic [7:0] seq[5];
      // Reset with every requester pending
      repeat (3) begin
         @(negedge clk_25mhz);
         chk_reset_outputs("reset");
      end
      @(posedge clk_25mhz); #5;
      want_first = 1'b1;
      resetn     = 1'b1;
      wait_strobes(5, 300);
      chk("first_ack_after_reset", 32'(first_ack), 32'b0001);
`ifdef UART_ARB_TAG_EN
      seq = '{8'h30, 8'h10, 8'h31, 8'h11, 8'h32};
`else
      seq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
`endif
      chk("log_size", 32'(strobe_log.size() >= 5), 1);
      if (strobe_log.size() >= 5)
         for (int i = 0; i < 5; i++) chk("rr_order", 32'(strobe_log[i]), 32'(seq[i]));

      // Transmitter that never raises busy
      @(posedge clk_25mhz); #5;
      busy_len = 0;
      wait_strobes(2, 300);
      @(posedge clk_25mhz); #5;
`ifndef UART_ARB_TAG_EN
      chk_spacing = 1'b1;
`endif
      wait_strobes(3, 300);
      @(posedge clk_25mhz); #5;
      chk_spacing = 1'b0;

      // Single requester with a long frame
      req_mode = 0;
      wait_idle(400);
      @(posedge clk_25mhz); #5;
      busy_len = 20;
      dat[2]   = 8'hA5;
      inject   = 4'b0100;
      @(posedge clk_25mhz); #5;
      inject = '0;
      wait_strobes(1, 100);
`ifdef UART_ARB_TAG_EN
      wait_strobes(1, 100);
`endif
      chk("single_byte", 32'(strobe_log[strobe_log.size()-1]), 32'hA5);
      wait_idle(100);

      // Reset while waiting for the frame to finish
      @(posedge clk_25mhz); #5;
      busy_len = 10;
      req_mode = 2;
      wait_strobes(1, 200);
      @(posedge clk_25mhz);
      @(posedge clk_25mhz); #5;
      resetn = 1'b0;
      @(posedge clk_25mhz);
      @(negedge clk_25mhz);
      chk_reset_outputs("midframe_reset");
      @(posedge clk_25mhz); #5;
      want_first = 1'b1;
      resetn     = 1'b1;
      wait_strobes(2, 300);
      chk("first_ack_after_midframe_reset", 32'(first_ack), 32'b0001);

      // Randomized producers and frame lengths
      @(posedge clk_25mhz); #5;
      rand_busy = 1'b1;
      req_mode  = 1;
      repeat (1500) @(posedge clk_25mhz);
      #5;
      req_mode = 0;
      wait_idle(600);
      repeat (3) @(negedge clk_25mhz);
      chk("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
